// File: rtl/seq_add_pkg.sv
// Shared definitions for the byte-serial adder: byte width, FSM states, index sizing.
package seq_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte index needs at least one bit even when only one byte is processed.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/bypass8.sv
// 8-bit carry-bypass adder: two 4-bit ripple nibbles, each skipped when fully propagating.
module bypass8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] s_o,
    output logic       cout_o
);

    logic [7:0] p;
    logic [4:0] lo_sum;
    logic [4:0] hi_sum;
    logic       lo_c;

    for (genvar gi = 0; gi < 8; gi++) begin : g_prop
        assign p[gi] = a_i[gi] ^ b_i[gi];
    end

    assign lo_sum = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, cin_i};
    assign lo_c   = (&p[3:0]) ? cin_i : lo_sum[4];
    assign hi_sum = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + {4'b0000, lo_c};
    assign cout_o = (&p[7:4]) ? lo_c : hi_sum[4];
    assign s_o    = {hi_sum[3:0], lo_sum[3:0]};

endmodule

// File: rtl/seq_add_nbytes.sv
// Byte-serial wide adder sequencing one bypass8 slice, LSB byte first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SEQ_ADD_OVF_EN.
module seq_add_nbytes
    import seq_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     busy
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = idx_width(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            out_valid_q, out_valid_d;
`ifdef SEQ_ADD_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic [BYTE_W-1:0] slice_a;
    logic [BYTE_W-1:0] slice_b;
    logic [BYTE_W-1:0] slice_s;
    logic              slice_cout;
    logic              accept;

    assign slice_a = a_q[idx_q*BYTE_W +: BYTE_W];
    assign slice_b = b_q[idx_q*BYTE_W +: BYTE_W];

    bypass8 u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .cout_o (slice_cout)
    );

    // Ready in DONE follows out_ready so a new operand set can enter as the result leaves.
    assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_ADD_OVF_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = slice_s;
                carry_d = slice_cout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    cout_d      = slice_cout;
                    out_valid_d = 1'b1;
`ifdef SEQ_ADD_OVF_EN
                    ovf_d = (a_q[W-1] == b_q[W-1]) && (slice_s[BYTE_W-1] != a_q[W-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (accept) begin
                        a_d     = a;
                        b_d     = b;
                        carry_d = cin;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == RUN);
`ifdef SEQ_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_add_nbytes.sv
// Randomised and directed bench for seq_add_nbytes against a plain-arithmetic model.
module tb_seq_add_nbytes;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SEQ_ADD_OVF_EN
    logic         ovf;
`endif

    seq_add_nbytes #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SEQ_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
    } op_t;

    op_t stim_q[$];
    op_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_ops    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_add(input op_t o);
        return {1'b0, o.a} + {1'b0, o.b} + (W+1)'(o.ci);
    endfunction

    function automatic logic ref_ovf(input op_t o);
        logic [W:0] r;
        r = ref_add(o);
        return (o.a[W-1] == o.b[W-1]) && (r[W-1] != o.a[W-1]);
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a  = $urandom;
        o.b  = $urandom;
        o.ci = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // mode 0: continuous valid/ready; mode 1: random valid/ready; mode 2: hold ready low 5 DONE cycles
    task automatic stream(input int nops, input int mode);
        int         issued = 0;
        int         completed = 0;
        int         run_left = 0;
        int         held = 0;
        int         cyc = 0;
        int         last_cons = -1;
        int         budget;
        bit         done = 0;
        bit         have_cur = 0;
        bit         exp_ready;
        bit         acc;
        op_t        cur;
        logic [W:0] r;
        budget = nops * (NB + 2) * 8 + 50;
        while (completed < nops && cyc < budget) begin
            @(negedge clk);
            cyc++;
            chk("busy", 64'(busy), 64'(run_left > 0));
            chk("out_valid", 64'(out_valid), 64'(done));
            if (done) begin
                r = ref_add(exp_q[0]);
                chk("sum", 64'(sum), 64'(r[W-1:0]));
                chk("cout", 64'(cout), 64'(r[W]));
`ifdef SEQ_ADD_OVF_EN
                chk("ovf", 64'(ovf), 64'(ref_ovf(exp_q[0])));
`endif
            end
            if (issued < nops && (mode != 1 || $urandom_range(0, 1) == 1)) begin
                if (!have_cur) begin
                    cur = (stim_q.size() > 0) ? stim_q.pop_front() : rand_op();
                    have_cur = 1;
                end
                in_valid = 1'b1;
                a = cur.a;
                b = cur.b;
                cin = cur.ci;
            end else begin
                in_valid = 1'b0;
                a = $urandom;
                b = $urandom;
                cin = 1'($urandom_range(0, 1));
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (held >= 5);
            endcase
            #1;
            exp_ready = (run_left == 0) && (!done || out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            acc = in_valid && exp_ready;
            if (run_left > 0) begin
                run_left--;
                if (run_left == 0) done = 1;
            end else begin
                if (done) begin
                    if (out_ready) begin
                        r = ref_add(exp_q[0]);
                        n_ops++;
                        $display("op %0d: a=%h b=%h cin=%0d -> sum=%h cout=%0d", n_ops,
                                 exp_q[0].a, exp_q[0].b, exp_q[0].ci, r[W-1:0], r[W]);
                        if (mode == 0 && last_cons >= 0)
                            chk("spacing", 64'(cyc - last_cons), 64'(NB + 1));
                        last_cons = cyc;
                        void'(exp_q.pop_front());
                        completed++;
                        done = 0;
                        held = 0;
                    end else begin
                        held++;
                    end
                end
                if (acc) begin
                    exp_q.push_back(cur);
                    have_cur = 0;
                    issued++;
                    run_left = NB;
                end
            end
        end
        chk("timeout", 64'(completed), 64'(nops));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    function automatic op_t mk(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        op_t o;
        o.a = av;
        o.b = bv;
        o.ci = ci;
        return o;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_sum"}, 64'(sum), 64'd0);
        chk({tag, "_cout"}, 64'(cout), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
`ifdef SEQ_ADD_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Ripple, full-propagate, signed overflow, back-to-back
        stim_q.push_back(mk(32'h0000_00FF, 32'h0000_0001, 1'b0));
        stim_q.push_back(mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1));
        stim_q.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0));
        stream(3, 0);

        stim_q.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0));
        stim_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1));
        stream(2, 2);

        stream(40, 1);

        // Abort after two RUN cycles
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h0FED_CBA9;
        cin = 1'b1;
        #1;
        chk("mid_accept_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy0", 64'(busy), 64'd1);
        @(negedge clk);
        chk("mid_busy1", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_reset_state("midrst");
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        stream(3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
